fec_viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/3, K=3 convolutional FEC used by `fec_pipelined`. It takes one 96-bit codeword (32 trellis symbols of 3 bits) and recovers the 32-bit data word. It sits on the receive side, directly opposite the encoder. It reports the Hamming distance between the received codeword and the decoded path, so upstream logic can flag link quality.

---
 rtl/fec_pkg.sv | 33 +++
 rtl/fec_viterbi_decoder_if.sv | 22 ++
 rtl/viterbi_acs.sv | 21 ++
 rtl/fec_viterbi_decoder.sv | 171 +++++++++++++++++
 tb/tb_fec_viterbi_decoder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fec_pkg.sv
// Shared constants, FSM encoding and trellis helpers for the rate-1/3, K=3 Viterbi decoder.
// The generator taps must stay identical to the transmit-side encoder.
package fec_pkg;

    localparam int N_BITS   = 32;
    localparam int K        = 3;
    localparam int N_STATES = 1 << (K - 1);
    localparam int PM_INIT  = 128;

    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
    localparam logic [2:0] G2 = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACS,
        ST_FINDMIN,
        ST_TRACE,
        ST_DONE
    } state_e;

    // Encoder output {g0,g1,g2} when bit_in is shifted into register {bit_in, prev_state}.
    function automatic logic [2:0] expected_sym(input logic [1:0] prev_state, input logic bit_in);
        logic [2:0] sr;
        sr = {bit_in, prev_state};
        return {^(sr & G0), ^(sr & G1), ^(sr & G2)};
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/fec_viterbi_decoder_if.sv
// Start/codeword request and decoded-result bundle between the receive path and the decoder.
interface fec_viterbi_decoder_if #(
    parameter int N_BITS = 32,
    parameter int MW     = 8
);
    logic                  start_in;
    logic [3*N_BITS-1:0]   fec_in;
    logic [N_BITS-1:0]     data_out;
    logic                  done_out;
    logic                  busy_out;
    logic [MW-1:0]         err_metric_out;

    modport master (
        output start_in, fec_in,
        input  data_out, done_out, busy_out, err_metric_out
    );

    modport slave (
        input  start_in, fec_in,
        output data_out, done_out, busy_out, err_metric_out
    );
endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; the lower-index predecessor wins ties.
module viterbi_acs #(
    parameter int MW = 8
) (
    input  logic [MW-1:0] pm0_in,
    input  logic [MW-1:0] pm1_in,
    input  logic [1:0]    bm0_in,
    input  logic [1:0]    bm1_in,
    output logic [MW-1:0] pm_out,
    output logic          dec_out
);
    logic [MW-1:0] cand0;
    logic [MW-1:0] cand1;

    always_comb begin
        cand0   = pm0_in + MW'(bm0_in);
        cand1   = pm1_in + MW'(bm1_in);
        dec_out = (cand1 < cand0);
        pm_out  = dec_out ? cand1 : cand0;
    end
endmodule

// File: rtl/fec_viterbi_decoder.sv
// Hard-decision Viterbi decoder: 32 ACS steps, min-metric end state search, 32-step traceback.
// Survivor decisions are kept in registers and read back one trellis step per cycle.
module fec_viterbi_decoder
    import fec_pkg::*;
#(
    parameter int N_BITS = fec_pkg::N_BITS,
    parameter int MW     = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    fec_viterbi_decoder_if.slave  bus
);
    localparam int CW    = 3 * N_BITS;
    localparam int CNT_W = $clog2(N_BITS);
    localparam int NS    = N_STATES;
    localparam int SW    = K - 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      sr_q, sr_d;
    logic [MW-1:0]      pm_q [NS];
    logic [MW-1:0]      pm_d [NS];
    logic [NS-1:0]      surv_q [N_BITS];
    logic [NS-1:0]      surv_d [N_BITS];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]      tb_state_q, tb_state_d;
    logic [N_BITS-1:0]  dec_q, dec_d;
    logic [N_BITS-1:0]  data_q, data_d;
    logic [MW-1:0]      min_q, min_d;
    logic [MW-1:0]      err_q, err_d;
    logic               done_q, done_d;

    logic [2:0]         rx_sym;
    logic [MW-1:0]      acs_pm [NS];
    logic [NS-1:0]      acs_dec;
    logic [MW-1:0]      min_val;
    logic [SW-1:0]      min_idx;

    assign rx_sym = sr_q[CW-1 -: 3];

    // Predecessors of s are {s[0],0} and {s[0],1}; the input bit on both branches is s[1].
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_acs
            localparam logic [SW-1:0] S  = SW'(gi);
            localparam logic [SW-1:0] P0 = {S[0], 1'b0};
            localparam logic [SW-1:0] P1 = {S[0], 1'b1};
            logic [1:0] bm0;
            logic [1:0] bm1;

            always_comb begin
                bm0 = popcount3(rx_sym ^ expected_sym(P0, S[1]));
                bm1 = popcount3(rx_sym ^ expected_sym(P1, S[1]));
            end

            viterbi_acs #(.MW(MW)) u_acs (
                .pm0_in  (pm_q[P0]),
                .pm1_in  (pm_q[P1]),
                .bm0_in  (bm0),
                .bm1_in  (bm1),
                .pm_out  (acs_pm[gi]),
                .dec_out (acs_dec[gi])
            );
        end
    endgenerate

    // Strict compare keeps the lowest-index state on equal metrics.
    always_comb begin
        min_val = pm_q[0];
        min_idx = '0;
        for (int i = 1; i < NS; i++) begin
            if (pm_q[i] < min_val) begin
                min_val = pm_q[i];
                min_idx = SW'(i);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            tb_state_q <= '0;
            dec_q      <= '0;
            data_q     <= '0;
            min_q      <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < NS; i++)     pm_q[i]   <= '0;
            for (int i = 0; i < N_BITS; i++) surv_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tb_state_q <= tb_state_d;
            dec_q      <= dec_d;
            data_q     <= data_d;
            min_q      <= min_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pm_q       <= pm_d;
            surv_q     <= surv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start_in) state_d = ST_ACS;
            ST_ACS:     if (cnt_q == CNT_W'(N_BITS - 1)) state_d = ST_FINDMIN;
            ST_FINDMIN: state_d = ST_TRACE;
            ST_TRACE:   if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sr_d       = sr_q;
        pm_d       = pm_q;
        surv_d     = surv_q;
        cnt_d      = cnt_q;
        tb_state_d = tb_state_q;
        dec_d      = dec_q;
        data_d     = data_q;
        min_d      = min_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    sr_d  = bus.fec_in;
                    cnt_d = '0;
                    pm_d[0] = '0;
                    for (int i = 1; i < NS; i++) pm_d[i] = MW'(PM_INIT);
                end
            end
            ST_ACS: begin
                sr_d          = sr_q << 3;
                pm_d          = acs_pm;
                surv_d[cnt_q] = acs_dec;
                cnt_d         = cnt_q + 1'b1;
            end
            ST_FINDMIN: begin
                tb_state_d = min_idx;
                min_d      = min_val;
                cnt_d      = CNT_W'(N_BITS - 1);
            end
            ST_TRACE: begin
                // Bits come out last-first, so shift in at the MSB and move right.
                dec_d      = {tb_state_q[1], dec_q[N_BITS-1:1]};
                tb_state_d = {tb_state_q[0], surv_q[cnt_q][tb_state_q]};
                cnt_d      = cnt_q - 1'b1;
            end
            ST_DONE: begin
                data_d = dec_q;
                err_d  = min_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy_out       = (state_q != ST_IDLE);
        bus.done_out       = done_q;
        bus.data_out       = data_q;
        bus.err_metric_out = err_q;
    end

endmodule

// File: tb/tb_fec_viterbi_decoder.sv
// Self-checking bench: fixed vector table, hand sequences for start/reset corners, and
// random single-error words checked against a register-exchange Viterbi reference model.
module tb_fec_viterbi_decoder;

    logic clk;
    logic rst_n;

    fec_viterbi_decoder_if #(.N_BITS(32), .MW(8)) bus ();

    fec_viterbi_decoder #(.N_BITS(32), .MW(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [2:0] gen_out(input logic [2:0] r);
        return {^(r & 3'b111), ^(r & 3'b101), ^(r & 3'b011)};
    endfunction

    function automatic logic [95:0] encode(input logic [31:0] d);
        logic [2:0]  r;
        logic [95:0] cw;
        r  = '0;
        cw = '0;
        for (int k = 0; k < 32; k++) begin
            r = {d[31-k], r[2:1]};
            cw[95-3*k -: 3] = gen_out(r);
        end
        return cw;
    endfunction

    // Register-exchange Viterbi: each state carries its whole decoded path.
    function automatic void ref_decode(input logic [95:0] cw, output logic [31:0] d, output int m);
        int          pm [4];
        int          npm [4];
        logic [31:0] path [4];
        logic [31:0] npath [4];
        int          idx;
        pm = '{0, 128, 128, 128};
        for (int s = 0; s < 4; s++) path[s] = '0;
        for (int k = 0; k < 32; k++) begin
            logic [2:0] sym;
            sym = cw[95-3*k -: 3];
            for (int s = 0; s < 4; s++) begin
                int          best;
                logic [31:0] bp;
                best = -1;
                bp   = '0;
                for (int j = 0; j < 2; j++) begin
                    int         p;
                    int         b;
                    int         c;
                    logic [2:0] r;
                    p = ((s & 1) << 1) | j;
                    b = s >> 1;
                    r = 3'((b << 2) | p);
                    c = pm[p] + $countones(sym ^ gen_out(r));
                    if (best < 0 || c < best) begin
                        best = c;
                        bp = path[p];
                        bp[31-k] = b[0];
                    end
                end
                npm[s]   = best;
                npath[s] = bp;
            end
            pm   = npm;
            path = npath;
        end
        idx = 0;
        for (int s = 1; s < 4; s++) if (pm[s] < pm[idx]) idx = s;
        d = path[idx];
        m = pm[idx];
    endfunction

    // Pulses start, optionally pulses a second (ignored) start extra_at edges later,
    // and returns the result plus the number of edges from the start edge to done.
    task automatic do_decode(input logic [95:0] cw, input int extra_at,
                             output logic [31:0] d, output logic [7:0] m, output int lat,
                             output int busy_lo);
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.fec_in   = cw;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.fec_in   = {$urandom, $urandom, $urandom};
        lat     = -1;
        busy_lo = 0;
        d       = '0;
        m       = '0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            bus.start_in = (i == extra_at);
            if (bus.done_out) begin
                lat = i;
                d   = bus.data_out;
                m   = bus.err_metric_out;
                break;
            end
            if (!bus.busy_out) busy_lo++;
        end
        bus.start_in = 1'b0;
        $display("txn cw=%024h data=%08h metric=%0d latency=%0d", cw, d, m, lat);
    endtask

    task automatic count_done(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_out) dones++;
        end
    endtask

    typedef struct {
        logic [95:0] cw;
        logic [31:0] exp_data;
        logic [7:0]  exp_metric;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [31:0] d;
        logic [7:0]  m;
        int          lat;
        int          busy_lo;
        int          dones;
        int          busy_cnt;

        rst_n        = 1'b0;
        bus.start_in = 1'b0;
        bus.fec_in   = '0;

        vecs[0] = '{96'h0, 32'h00000000, 8'd0};
        vecs[1] = '{96'hD78000000000000000000000, 32'h80000000, 8'd0};
        vecs[2] = '{96'h578000000000000000000000, 32'h80000000, 8'd1};
        vecs[3] = '{encode(32'h03010203), 32'h03010203, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", bus.data_out, 0);
        check("reset err_metric_out", bus.err_metric_out, 0);
        check("reset done_out", bus.done_out, 0);
        check("reset busy_out", bus.busy_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        dones    = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_out) dones++;
            if (bus.busy_out) busy_cnt++;
        end
        $display("txn idle 100 cycles dones=%0d busy_cycles=%0d", dones, busy_cnt);
        check("idle done count", dones, 0);
        check("idle busy count", busy_cnt, 0);
        check("idle data_out", bus.data_out, 0);

        for (int v = 0; v < 4; v++) begin
            do_decode(vecs[v].cw, -1, d, m, lat, busy_lo);
            check($sformatf("vec%0d data", v), d, vecs[v].exp_data);
            check($sformatf("vec%0d metric", v), m, vecs[v].exp_metric);
            check($sformatf("vec%0d latency", v), lat, 66);
            check($sformatf("vec%0d busy gap", v), busy_lo, 0);
            check($sformatf("vec%0d busy after done", v), bus.busy_out, 0);
        end

        // Second start mid-decode must neither corrupt the result nor queue another run.
        do_decode(encode(32'hCAFE1234), 10, d, m, lat, busy_lo);
        check("ignored start data", d, 32'hCAFE1234);
        check("ignored start metric", m, 0);
        check("ignored start latency", lat, 66);
        count_done(80, dones);
        $display("txn after ignored start dones=%0d", dones);
        check("ignored start no second done", dones, 0);
        check("result held", bus.data_out, 32'hCAFE1234);

        // Reset during traceback aborts the decode and clears the held outputs.
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.fec_in   = encode(32'h5A5A0FF0);
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        $display("txn reset in trace data=%08h metric=%0d busy=%0d done=%0d",
                 bus.data_out, bus.err_metric_out, bus.busy_out, bus.done_out);
        check("mid reset data_out", bus.data_out, 0);
        check("mid reset err_metric_out", bus.err_metric_out, 0);
        check("mid reset busy_out", bus.busy_out, 0);
        check("mid reset done_out", bus.done_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(80, dones);
        check("post reset no done", dones, 0);
        do_decode(encode(32'h5A5A0FF0), -1, d, m, lat, busy_lo);
        check("post reset data", d, 32'h5A5A0FF0);
        check("post reset metric", m, 0);
        check("post reset latency", lat, 66);

        for (int t = 0; t < 1000; t++) begin
            logic [31:0] w;
            logic [95:0] cw;
            logic [31:0] ref_d;
            int          ref_m;
            int          pos;
            w   = $urandom;
            cw  = encode(w);
            pos = $urandom_range(95, 0);
            cw[pos] = ~cw[pos];
            ref_decode(cw, ref_d, ref_m);
            do_decode(cw, -1, d, m, lat, busy_lo);
            check($sformatf("rand%0d data vs model", t), d, ref_d);
            check($sformatf("rand%0d metric vs model", t), m, ref_m);
            check($sformatf("rand%0d metric", t), m, 1);
            // Only the last symbol's g0/g1 bits leave a tie with the flipped-last-bit path.
            if (pos != 1 && pos != 2) check($sformatf("rand%0d recovery", t), d, w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
